// File: rtl/axi_stream_interface_pkg.sv
// ---------------------------------------------------------------------------
// axi_stream_pkg
// Shared definitions for the AXI-Stream buffering slice:
//   AXIS_DATA_WIDTH : default payload width of a stream beat
//   axis_beat_t     : one stored beat, {last, data}
//   ptr_width()     : ceil(log2(depth)), width of a FIFO pointer
// ---------------------------------------------------------------------------
package axi_stream_pkg;

    localparam int AXIS_DATA_WIDTH = 32;

    typedef struct packed {
        logic                       last;
        logic [AXIS_DATA_WIDTH-1:0] data;
    } axis_beat_t;

    // Smallest w with 2**w >= depth; never below 1 so a pointer always exists.
    function automatic int ptr_width(input int depth);
        int w;
        int one;
        w   = 1;
        one = 1;
        for (int i = 1; i < 31; i++) begin
            if ((one << i) < depth) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/axi_stream_interface_if.sv
// ---------------------------------------------------------------------------
// AXI_STREAM_BUS
// One AXI-Stream link. The master drives valid/last/data, the slave drives
// ready. A beat moves on every clock edge where valid and ready are both 1.
// ---------------------------------------------------------------------------
interface AXI_STREAM_BUS
    import axi_stream_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH
);
    logic                  valid;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (output valid, output last, output data, input ready);
    modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/axi_stream_interface_axis_beat_fifo.sv
// ---------------------------------------------------------------------------
// axis_beat_fifo
// DEPTH-entry synchronous FIFO of beat_t records with registered flags.
//   clk, rst    : clock, asynchronous active-high reset
//   push_i      : write wr_beat_i (ignored when full)
//   pop_i       : drop the head entry (ignored when empty)
//   rd_beat_o   : head entry, straight from storage
//   full_o      : count == DEPTH (registered)
//   empty_o     : count == 0     (registered)
// Storage is reset as well, so the head reads as all-zero after reset.
// ---------------------------------------------------------------------------
module axis_beat_fifo
    import axi_stream_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type beat_t = axis_beat_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  beat_t wr_beat_i,
    input  logic  pop_i,
    output beat_t rd_beat_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int              PW      = ptr_width(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1'b1);

    beat_t           mem_q [DEPTH];
    beat_t           mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            push_s, pop_s;

    // Next-state for storage, pointers, occupancy and flags.
    always_comb begin
        push_s   = push_i & ~full_q;
        pop_s    = pop_i & ~empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = wr_beat_i;
            // Power-of-two depth: pointer wraps by natural overflow.
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == {CW{1'b0}});
    end

    // State registers; reset empties the FIFO and clears storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_beat_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/axi_stream_interface.sv
// ---------------------------------------------------------------------------
// axi_stream_interface
// Elastic AXI-Stream slice holding up to DEPTH beats.
//   s_axis_clk    : clock
//   s_axis_resetn : asynchronous reset, active HIGH despite the name
//   m_axis        : upstream stream in  (slave modport, we drive ready)
//   s_axis        : downstream stream out (master modport, we drive valid)
// ready and valid come only from registered state, so there is no
// combinational path from m_axis.valid or s_axis.ready to either.
// ---------------------------------------------------------------------------
module axi_stream_interface
    import axi_stream_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input logic            s_axis_clk,
    input logic            s_axis_resetn,
    AXI_STREAM_BUS.slave   m_axis,
    AXI_STREAM_BUS.master  s_axis
);
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t wr_beat_s;
    beat_t rd_beat_s;
    logic  full_s;
    logic  empty_s;
    logic  push_s;
    logic  pop_s;
    logic  in_ready_s;
    logic  run_q, run_d;

    // run_q is 0 during reset and rises on the first edge after release,
    // holding m_axis.ready low while in reset.
    always_comb begin
        run_d = 1'b1;
    end

    // Run flag register.
    always_ff @(posedge s_axis_clk or posedge s_axis_resetn) begin
        if (s_axis_resetn) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    assign in_ready_s      = run_q & ~full_s;
    assign push_s          = m_axis.valid & in_ready_s;
    assign pop_s           = s_axis.ready & ~empty_s;
    assign wr_beat_s.last  = m_axis.last;
    assign wr_beat_s.data  = m_axis.data;

    assign m_axis.ready    = in_ready_s;
    assign s_axis.valid    = ~empty_s;
    assign s_axis.last     = rd_beat_s.last;
    assign s_axis.data     = rd_beat_s.data;

    axis_beat_fifo #(
        .DEPTH  (DEPTH),
        .beat_t (beat_t)
    ) u_fifo (
        .clk       (s_axis_clk),
        .rst       (s_axis_resetn),
        .push_i    (push_s),
        .wr_beat_i (wr_beat_s),
        .pop_i     (pop_s),
        .rd_beat_o (rd_beat_s),
        .full_o    (full_s),
        .empty_o   (empty_s)
    );

endmodule

// File: tb/tb_axi_stream_interface.sv
module tb_axi_stream_interface;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    AXI_STREAM_BUS #(.DATA_WIDTH(DW)) m_if ();
    AXI_STREAM_BUS #(.DATA_WIDTH(DW)) s_if ();

    axi_stream_interface #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .s_axis_clk    (clk),
        .s_axis_resetn (rst),
        .m_axis        (m_if),
        .s_axis        (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: the FIFO contents as a plain queue of {last, data}.
    logic [DW:0] mq[$];
    int          n_out;

    typedef struct {
        bit          iv;
        bit          il;
        logic [31:0] id;
        bit          ordy;
        bit          ev;
        bit          el;
        logic [31:0] ed;
        bit          er;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_if.valid = 1'b0;
        s_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        @(posedge clk);
        #1;
    endtask

    // One clock of model-checked traffic; called #1 after an edge.
    task automatic mcycle(input bit v, input bit l, input logic [31:0] d, input bit r);
        bit push;
        bit pop;
        m_if.valid = v;
        m_if.last  = l;
        m_if.data  = d;
        s_if.ready = r;
        check("m_ready", {63'd0, m_if.ready}, {63'd0, (mq.size() < DEPTH)});
        check("s_valid", {63'd0, s_if.valid}, {63'd0, (mq.size() != 0)});
        if (mq.size() != 0) begin
            check("s_data", {32'd0, s_if.data}, {32'd0, mq[0][DW-1:0]});
            check("s_last", {63'd0, s_if.last}, {63'd0, mq[0][DW]});
        end
        push = v && (mq.size() < DEPTH);
        pop  = r && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(mq.pop_front());
            n_out++;
        end
        if (push) mq.push_back({l, d});
    endtask

    initial begin
        int sent;
        int cyc;
        bit v;
        rst = 1'b1;
        m_if.valid = 1'b0;
        m_if.last  = 1'b1;
        m_if.data  = 32'h0A1B2C3D;
        s_if.ready = 1'b0;

        // ---- reset and idle ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_valid", {63'd0, s_if.valid}, 64'd0);
        check("rst_s_data",  {32'd0, s_if.data},  64'd0);
        check("rst_s_last",  {63'd0, s_if.last},  64'd0);
        check("rst_m_ready", {63'd0, m_if.ready}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_m_ready", {63'd0, m_if.ready}, 64'd1);
        check("rel_s_valid", {63'd0, s_if.valid}, 64'd0);

        // ---- single beat ----
        m_if.valid = 1'b1;
        m_if.last  = 1'b1;
        m_if.data  = 32'h0A1B2C3D;
        @(posedge clk);
        #1;
        m_if.valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("single_valid", {63'd0, s_if.valid}, 64'd1);
            check("single_data",  {32'd0, s_if.data},  64'h0A1B2C3D);
            check("single_last",  {63'd0, s_if.last},  64'd1);
            @(posedge clk);
            #1;
        end
        s_if.ready = 1'b1;
        @(posedge clk);
        #1;
        check("single_popped", {63'd0, s_if.valid}, 64'd0);

        // ---- fill to full (table) ----
        do_reset();
        vecs[0]  = '{1'b1, 1'b0, 32'h1, 1'b0, 1'b1, 1'b0, 32'h1, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 32'h2, 1'b0, 1'b1, 1'b0, 32'h1, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'h3, 1'b0, 1'b1, 1'b0, 32'h1, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h4, 1'b0, 1'b1, 1'b0, 32'h1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h5, 1'b0, 1'b1, 1'b0, 32'h1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h5, 1'b1, 1'b1, 1'b0, 32'h2, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 32'h5, 1'b0, 1'b1, 1'b0, 32'h2, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h3, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h4, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h5, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            m_if.valid = vecs[i].iv;
            m_if.last  = vecs[i].il;
            m_if.data  = vecs[i].id;
            s_if.ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("fill%0d_valid", i), {63'd0, s_if.valid}, {63'd0, vecs[i].ev});
            check($sformatf("fill%0d_ready", i), {63'd0, m_if.ready}, {63'd0, vecs[i].er});
            if (vecs[i].ev) begin
                check($sformatf("fill%0d_data", i), {32'd0, s_if.data}, {32'd0, vecs[i].ed});
                check($sformatf("fill%0d_last", i), {63'd0, s_if.last}, {63'd0, vecs[i].el});
            end
        end

        // ---- streaming 0x10..0x1F ----
        do_reset();
        n_out = 0;
        for (int i = 0; i < 16; i++) begin
            mcycle(1'b1, (i == 15), 32'h10 + i, 1'b1);
            check("stream_latency", {32'd0, s_if.data}, 64'h10 + i);
        end
        for (int i = 0; i < 3; i++) mcycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("stream_count", n_out, 64'd16);

        // ---- random back-pressure, 1000 beats ----
        do_reset();
        n_out = 0;
        sent  = 0;
        cyc   = 0;
        while (sent < 1000 && cyc < 20000) begin
            v = ($urandom_range(0, 3) != 0);
            if (v && mq.size() < DEPTH) sent++;
            mcycle(v, $urandom_range(0, 1), $urandom, ($urandom_range(0, 2) != 0));
            cyc++;
        end
        check("rand_sent_in_budget", sent, 64'd1000);
        cyc = 0;
        while (mq.size() != 0 && cyc < 100) begin
            mcycle(1'b0, 1'b0, 32'h0, 1'b1);
            cyc++;
        end
        check("rand_drained", mq.size(), 64'd0);
        check("rand_out_count", n_out, 64'd1000);

        // ---- reset mid-packet ----
        do_reset();
        for (int i = 0; i < 3; i++) mcycle(1'b1, (i == 2), 32'hA0 + i, 1'b0);
        check("mid_valid_before", {63'd0, s_if.valid}, 64'd1);
        m_if.valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, s_if.valid}, 64'd0);
        check("mid_rst_data",  {32'd0, s_if.data},  64'd0);
        check("mid_rst_ready", {63'd0, m_if.ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) mcycle(1'b0, 1'b0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
